// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS core: boot PC, fetch FSM states
// and the redirect-target computation used by both fetch and decode.
package mips_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_t;

    // Branch beats jump beats jump-register; callers gate the result with
    // "any redirect present", so jr is the fall-through case here.
    function automatic logic [31:0] redir_target(
        input logic        is_branch,
        input logic [31:0] branch_addr,
        input logic        is_jump,
        input logic [25:0] jump_addr,
        input logic [31:0] jump_reg_addr,
        input logic [31:0] redir_pc
    );
        logic [31:0] target;
        if (is_branch) begin
            target = redir_pc + 32'd4 + {branch_addr[29:0], 2'b00};
        end else if (is_jump) begin
            target = {redir_pc[31:28], jump_addr, 2'b00};
        end else begin
            target = {jump_reg_addr[31:2], 2'b00};
        end
        return target;
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/grant/response port plus the fetch-to-decode
// valid/ready handshake; the fetch unit is the master of both.
interface fetch_ctrl_if;

    logic        im_req;
    logic [31:0] im_addr;
    logic        im_gnt;
    logic        im_rvalid;
    logic [31:0] im_rdata;

    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_pc;
    logic [31:0] inst;

    modport master (
        output im_req, im_addr, inst_valid, inst_pc, inst,
        input  im_gnt, im_rvalid, im_rdata, inst_ready
    );

    modport slave (
        input  im_req, im_addr, inst_valid, inst_pc, inst,
        output im_gnt, im_rvalid, im_rdata, inst_ready
    );

endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues one memory request at a
// time, buffers the returned word for decode and squashes wrong-path fetches.
module fetch_ctrl
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                isBranch,
    input  logic [31:0]         branchAddr,
    input  logic                isJump,
    input  logic [25:0]         jumpAddr,
    input  logic                isJumpReg,
    input  logic [31:0]         jumpRegAddr,
    input  logic [31:0]         redirPC,
    fetch_ctrl_if.master        bus,
    output logic [31:0]         fetch_count
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  req_addr_q, req_addr_d;
    logic [31:0]  inst_q, inst_d;
    logic [31:0]  inst_pc_q, inst_pc_d;
    logic [31:0]  fetch_count_q, fetch_count_d;
    logic         kill_q, kill_d;
    logic         im_req_q, im_req_d;
    logic         inst_valid_q, inst_valid_d;

    logic         redir;
    logic [31:0]  target;

    assign redir  = isBranch | isJump | isJumpReg;
    assign target = redir_target(isBranch, branchAddr, isJump, jumpAddr,
                                 jumpRegAddr, redirPC);

    // NOTE: every always_comb output gets a default before the case so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d       = state_q;
        pc_d          = redir ? target : pc_q;
        req_addr_d    = req_addr_q;
        inst_d        = inst_q;
        inst_pc_d     = inst_pc_q;
        fetch_count_d = fetch_count_q;
        kill_d        = kill_q;

        case (state_q)
            IDLE: begin
                req_addr_d = pc_q;
                state_d    = REQ;
            end

            // The address must stay put until granted, so a redirect here
            // only marks the eventual response as stale.
            REQ: begin
                if (redir) begin
                    kill_d = 1'b1;
                end
                if (bus.im_gnt) begin
                    state_d = WAIT;
                end
            end

            WAIT: begin
                if (bus.im_rvalid) begin
                    if (kill_q || redir) begin
                        kill_d     = 1'b0;
                        req_addr_d = pc_d;
                        state_d    = REQ;
                    end else begin
                        inst_d    = bus.im_rdata;
                        inst_pc_d = req_addr_q;
                        state_d   = HOLD;
                    end
                end else if (redir) begin
                    kill_d = 1'b1;
                end
            end

            // A handshake completes before a same-cycle redirect takes effect.
            HOLD: begin
                if (bus.inst_ready) begin
                    fetch_count_d = fetch_count_q + 32'd1;
                    pc_d          = redir ? target : pc_q + 32'd4;
                    req_addr_d    = pc_d;
                    state_d       = REQ;
                end else if (redir) begin
                    inst_d     = '0;
                    inst_pc_d  = '0;
                    req_addr_d = target;
                    state_d    = REQ;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        im_req_d     = (state_d == REQ);
        inst_valid_d = (state_d == HOLD);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            req_addr_q    <= '0;
            inst_q        <= '0;
            inst_pc_q     <= '0;
            fetch_count_q <= '0;
            kill_q        <= 1'b0;
            im_req_q      <= 1'b0;
            inst_valid_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            req_addr_q    <= req_addr_d;
            inst_q        <= inst_d;
            inst_pc_q     <= inst_pc_d;
            fetch_count_q <= fetch_count_d;
            kill_q        <= kill_d;
            im_req_q      <= im_req_d;
            inst_valid_q  <= inst_valid_d;
        end
    end

    assign bus.im_req     = im_req_q;
    assign bus.im_addr    = req_addr_q;
    assign bus.inst_valid = inst_valid_q;
    assign bus.inst_pc    = inst_pc_q;
    assign bus.inst       = inst_q;
    assign fetch_count    = fetch_count_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a wait-state-programmable memory model, a
// protocol monitor, and hand-computed expectations for each scenario.
module tb_fetch_ctrl;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        isBranch, isJump, isJumpReg;
    logic [31:0] branchAddr, jumpRegAddr, redirPC;
    logic [25:0] jumpAddr;
    logic [31:0] fetch_count;

    fetch_ctrl_if bus ();

    fetch_ctrl #(.RESET_PC(32'h0000_3000)) dut (
        .clk         (clk),
        .reset       (reset),
        .isBranch    (isBranch),
        .branchAddr  (branchAddr),
        .isJump      (isJump),
        .jumpAddr    (jumpAddr),
        .isJumpReg   (isJumpReg),
        .jumpRegAddr (jumpRegAddr),
        .redirPC     (redirPC),
        .bus         (bus),
        .fetch_count (fetch_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h0000_3000) ? 32'h2401_0005 : (32'hC0DE_0000 | {16'h0000, a[15:0]});
    endfunction

    // Memory model: grant after gnt_dly extra REQ cycles, respond after
    // rv_dly extra WAIT cycles; a reset discards anything outstanding.
    int          gnt_dly = 0;
    int          rv_dly  = 0;
    int          gcnt, rcnt;
    logic        mem_pending;
    logic [31:0] mem_addr;

    initial begin
        bus.im_gnt    = 1'b0;
        bus.im_rvalid = 1'b0;
        bus.im_rdata  = '0;
        mem_pending   = 1'b0;
        gcnt          = 0;
        rcnt          = 0;
        forever begin
            @(posedge clk);
            #2;
            bus.im_gnt    = 1'b0;
            bus.im_rvalid = 1'b0;
            if (!reset) begin
                mem_pending = 1'b0;
                gcnt        = 0;
                rcnt        = 0;
            end else if (mem_pending) begin
                if (rcnt >= rv_dly) begin
                    bus.im_rvalid = 1'b1;
                    bus.im_rdata  = mem_word(mem_addr);
                    mem_pending   = 1'b0;
                end else begin
                    rcnt++;
                end
            end else if (bus.im_req) begin
                if (gcnt >= gnt_dly) begin
                    bus.im_gnt  = 1'b1;
                    mem_pending = 1'b1;
                    mem_addr    = bus.im_addr;
                    gcnt        = 0;
                    rcnt        = 0;
                end else begin
                    gcnt++;
                end
            end
        end
    end

    // Protocol monitor, sampled mid-cycle when inputs and outputs are settled.
    int          cyc = 0;
    int          addr_viol = 0, outst_viol = 0, hold_viol = 0, out_n = 0;
    logic        prev_req, prev_gnt, prev_valid, prev_ready;
    logic [31:0] prev_addr, prev_inst, prev_pc;
    logic [31:0] req_addr_log[$];
    int          req_cyc_log[$];
    logic [31:0] dlv_pc[$];
    logic [31:0] dlv_inst[$];

    always @(negedge clk or negedge reset) begin
        if (!reset) begin
            prev_req   = 1'b0;
            prev_gnt   = 1'b0;
            prev_valid = 1'b0;
            prev_ready = 1'b0;
            out_n      = 0;
        end else begin
            cyc++;
            if (bus.im_req && !prev_req) begin
                req_addr_log.push_back(bus.im_addr);
                req_cyc_log.push_back(cyc);
            end
            if (bus.im_req && prev_req && !prev_gnt && bus.im_addr !== prev_addr) addr_viol++;
            if (bus.im_req && bus.im_gnt) begin
                if (out_n != 0) outst_viol++;
                out_n++;
            end
            if (bus.im_rvalid && out_n > 0) out_n--;
            if (bus.inst_valid && prev_valid && !prev_ready &&
                (bus.inst !== prev_inst || bus.inst_pc !== prev_pc)) hold_viol++;
            if (bus.inst_valid && bus.inst_ready) begin
                dlv_pc.push_back(bus.inst_pc);
                dlv_inst.push_back(bus.inst);
            end
            prev_req   = bus.im_req;
            prev_gnt   = bus.im_gnt;
            prev_addr  = bus.im_addr;
            prev_valid = bus.inst_valid;
            prev_ready = bus.inst_ready;
            prev_inst  = bus.inst;
            prev_pc    = bus.inst_pc;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_valid(input string tag);
        int i = 0;
        while (!bus.inst_valid && i < 60) begin
            step(1);
            i++;
        end
        check({tag, "_timeout"}, {31'd0, !bus.inst_valid}, 32'd0);
    endtask

    task automatic wait_count(input string tag, input logic [31:0] n);
        int i = 0;
        while (fetch_count != n && i < 100) begin
            step(1);
            i++;
        end
        check({tag, "_timeout"}, {31'd0, fetch_count != n}, 32'd0);
    endtask

    task automatic wait_req_eq(input string tag, input logic [31:0] a);
        int i = 0;
        while (!(bus.im_req && bus.im_addr == a) && i < 100) begin
            step(1);
            i++;
        end
        check({tag, "_timeout"}, {31'd0, !(bus.im_req && bus.im_addr == a)}, 32'd0);
    endtask

    task automatic wait_req_ne(input string tag, input logic [31:0] skip, output logic [31:0] a);
        int i = 0;
        while (!(bus.im_req && bus.im_addr != skip) && i < 100) begin
            step(1);
            i++;
        end
        check({tag, "_timeout"}, {31'd0, !(bus.im_req && bus.im_addr != skip)}, 32'd0);
        a = bus.im_addr;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_im_req"},      {31'd0, bus.im_req},     32'd0);
        check({tag, "_im_addr"},     bus.im_addr,             32'd0);
        check({tag, "_inst_valid"},  {31'd0, bus.inst_valid}, 32'd0);
        check({tag, "_inst"},        bus.inst,                32'd0);
        check({tag, "_inst_pc"},     bus.inst_pc,             32'd0);
        check({tag, "_fetch_count"}, fetch_count,             32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int          b_req, b_dlv, nreq, nwait, nstale;
        logic [31:0] a, bp_pc, bp_inst;

        reset = 1'b0;
        isBranch = 1'b0; isJump = 1'b0; isJumpReg = 1'b0;
        branchAddr = '0; jumpAddr = '0; jumpRegAddr = '0; redirPC = '0;
        bus.inst_ready = 1'b0;
        step(3);
        check_reset_outputs("reset");

        // Boot: zero-wait memory, decode always ready.
        b_req = req_addr_log.size();
        b_dlv = dlv_pc.size();
        bus.inst_ready = 1'b1;
        reset = 1'b1;
        step(1);
        check("boot_req",  {31'd0, bus.im_req}, 32'd1);
        check("boot_addr", bus.im_addr, 32'h0000_3000);
        wait_count("boot_count", 32'd3);
        bus.inst_ready = 1'b0;
        check("boot_count", fetch_count, 32'd3);
        check("boot_addr0", req_addr_log[b_req],     32'h0000_3000);
        check("boot_addr1", req_addr_log[b_req + 1], 32'h0000_3004);
        check("boot_addr2", req_addr_log[b_req + 2], 32'h0000_3008);
        check("boot_gap1",  req_cyc_log[b_req + 1] - req_cyc_log[b_req],     32'd3);
        check("boot_gap2",  req_cyc_log[b_req + 2] - req_cyc_log[b_req + 1], 32'd3);
        check("boot_pc0",   dlv_pc[b_dlv],   32'h0000_3000);
        check("boot_inst0", dlv_inst[b_dlv], 32'h2401_0005);

        // Backpressure on the 0x300C fetch.
        wait_valid("bp_valid");
        nreq = 0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            if (bus.im_req) nreq++;
        end
        bp_pc   = bus.inst_pc;
        bp_inst = bus.inst;
        check("bp_valid",  {31'd0, bus.inst_valid}, 32'd1);
        check("bp_pc",     bp_pc,   32'h0000_300C);
        check("bp_inst",   bp_inst, 32'hC0DE_300C);
        check("bp_no_req", nreq, 32'd0);
        check("bp_count",  fetch_count, 32'd3);

        // Wait states: grant two cycles late, response three cycles late.
        gnt_dly = 2;
        rv_dly  = 3;
        bus.inst_ready = 1'b1;
        step(1);
        bus.inst_ready = 1'b0;
        nreq  = 0;
        nwait = 0;
        for (int i = 0; i < 40 && !bus.inst_valid; i++) begin
            if (bus.im_req) nreq++;
            else nwait++;
            step(1);
        end
        check("ws_req_cycles",  nreq,  32'd3);
        check("ws_wait_cycles", nwait, 32'd4);
        check("ws_pc",    bus.inst_pc, 32'h0000_3010);
        check("ws_inst",  bus.inst,    32'hC0DE_3010);
        check("ws_count", fetch_count, 32'd4);

        // Asynchronous reset while the 0x3014 fetch sits in WAIT.
        bus.inst_ready = 1'b1;
        step(1);
        bus.inst_ready = 1'b0;
        step(3);
        check("pre_rst_in_wait", {31'd0, bus.im_req},     32'd0);
        check("pre_rst_count",   fetch_count,             32'd5);
        #1;
        reset = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        gnt_dly = 0;
        rv_dly  = 2;
        step(2);
        b_dlv = dlv_pc.size();
        bus.inst_ready = 1'b1;
        reset = 1'b1;
        step(1);
        check("restart_req",  {31'd0, bus.im_req}, 32'd1);
        check("restart_addr", bus.im_addr, 32'h0000_3000);

        // Jump while the 0x3008 fetch is in WAIT: its response must be dropped.
        wait_req_eq("kill_find", 32'h0000_3008);
        step(1);
        check("kill_in_wait", {31'd0, bus.im_req}, 32'd0);
        isJump   = 1'b1;
        jumpAddr = 26'h000_0C10;
        redirPC  = 32'h0000_3004;
        bus.inst_ready = 1'b0;
        step(1);
        isJump = 1'b0;
        wait_req_ne("kill_next", 32'h0000_3008, a);
        check("kill_target", a, 32'h0000_3040);
        wait_valid("kill_valid");
        check("kill_pc",   bus.inst_pc, 32'h0000_3040);
        check("kill_inst", bus.inst,    32'hC0DE_3040);
        check("kill_count", fetch_count, 32'd2);
        nstale = 0;
        for (int i = b_dlv; i < dlv_pc.size(); i++) begin
            if (dlv_pc[i] == 32'h0000_3008) nstale++;
        end
        check("kill_no_3008", nstale, 32'd0);

        // Branch and jr together in HOLD without ready: branch wins, buffer flushed.
        isBranch    = 1'b1;
        branchAddr  = 32'hFFFF_FFFE;
        redirPC     = 32'h0000_3010;
        isJumpReg   = 1'b1;
        jumpRegAddr = 32'h5555_5557;
        step(1);
        isBranch  = 1'b0;
        isJumpReg = 1'b0;
        check("prio_req",   {31'd0, bus.im_req},     32'd1);
        check("prio_addr",  bus.im_addr,             32'h0000_300C);
        check("prio_flush", {31'd0, bus.inst_valid}, 32'd0);
        check("prio_count", fetch_count,             32'd2);
        wait_valid("prio_valid");
        check("prio_pc", bus.inst_pc, 32'h0000_300C);

        // jr in HOLD with ready: delivered first, next fetch at the jr target.
        gnt_dly     = 2;
        isJumpReg   = 1'b1;
        jumpRegAddr = 32'h0000_4123;
        bus.inst_ready = 1'b1;
        step(1);
        isJumpReg = 1'b0;
        bus.inst_ready = 1'b0;
        check("jr_count",    fetch_count, 32'd3);
        check("jr_req",      {31'd0, bus.im_req}, 32'd1);
        check("jr_addr",     bus.im_addr, 32'h0000_4120);
        check("jr_dlv_pc",   dlv_pc[dlv_pc.size() - 1], 32'h0000_300C);

        // Jump while the request is still waiting for grant: address holds.
        isJump   = 1'b1;
        jumpAddr = 26'h000_0100;
        redirPC  = 32'h0000_3000;
        step(1);
        isJump = 1'b0;
        check("reqkill_req",  {31'd0, bus.im_req}, 32'd1);
        check("reqkill_addr", bus.im_addr, 32'h0000_4120);
        wait_req_ne("reqkill_next", 32'h0000_4120, a);
        check("reqkill_target", a, 32'h0000_0400);
        wait_valid("reqkill_valid");
        check("reqkill_pc",    bus.inst_pc, 32'h0000_0400);
        check("reqkill_inst",  bus.inst,    32'hC0DE_0400);
        check("reqkill_count", fetch_count, 32'd3);

        check("addr_stable",     addr_viol,  32'd0);
        check("one_outstanding", outst_viol, 32'd0);
        check("hold_stable",     hold_viol,  32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
